flag_hazard_ctrl: RTL and testbench

Sequencing and hazard controller for the NZCV flag register in the 5-stage pipeline. Tracks every in-flight flag-setting instruction (ADDS/SUBS) from EX through WB, drives the flag register's write-enable and data at WB, and supplies the correct up-to-date flags to the B.cond evaluated in ID. Resolves flag read-after-write hazards by forwarding, or by a one-cycle stall when EX forwarding is compiled out.

---
 rtl/flag_hazard_ctrl.sv | 75 +++++++
 tb/tb_flag_hazard_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/flag_hazard_ctrl.sv
// NZCV flag sequencing and RAW hazard control from EX through WB for the 5-stage pipeline.
// Build option: define FLAG_EX_FWD_EN to forward EX flags to ID; otherwise a one-cycle stall is used.
module flag_hazard_ctrl #(
    parameter int unsigned FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_set_flags,
    input  logic              id_use_flags,
    input  logic [FLAG_W-1:0] ex_alu_flags,
    input  logic [FLAG_W-1:0] arch_flags,
    input  logic              flush,
    input  logic              hold,
    output logic              flag_wr_en,
    output logic [FLAG_W-1:0] flag_wr_data,
    output logic [FLAG_W-1:0] id_flags,
    output logic              flag_stall
);

    logic              ex_v;
    logic              mem_v;
    logic              wb_v;
    logic [FLAG_W-1:0] mem_f;
    logic [FLAG_W-1:0] wb_f;

    // Tracker pipeline; in-flight writers are dropped on reset, never committed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_v  <= 1'b0;
            mem_v <= 1'b0;
            wb_v  <= 1'b0;
            mem_f <= '0;
            wb_f  <= '0;
        end else if (!hold) begin
            ex_v  <= id_set_flags & ~flag_stall & ~flush;
            mem_v <= ex_v;
            mem_f <= ex_alu_flags;
            wb_v  <= mem_v;
            wb_f  <= mem_f;
        end
    end

    // Commit at WB; a frozen pipeline must not write the same flags twice
    always_comb begin
        flag_wr_en   = wb_v & ~hold;
        flag_wr_data = wb_v ? wb_f : '0;
    end

`ifdef FLAG_EX_FWD_EN
    // Youngest valid writer wins, EX included
    always_comb begin
        flag_stall = 1'b0;
        if (ex_v)
            id_flags = ex_alu_flags;
        else if (mem_v)
            id_flags = mem_f;
        else if (wb_v)
            id_flags = wb_f;
        else
            id_flags = arch_flags;
    end
`else
    // EX excluded from selection; a reader behind an EX writer waits one cycle for MEM
    always_comb begin
        flag_stall = id_use_flags & ex_v;
        if (mem_v)
            id_flags = mem_f;
        else if (wb_v)
            id_flags = wb_f;
        else
            id_flags = arch_flags;
    end
`endif

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Directed bench for flag_hazard_ctrl; models the NZCV register and checks with immediate assertions.
module tb_flag_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       id_set_flags;
    logic       id_use_flags;
    logic [3:0] ex_alu_flags;
    logic [3:0] arch_flags;
    logic       flush;
    logic       hold;
    logic       flag_wr_en;
    logic [3:0] flag_wr_data;
    logic [3:0] id_flags;
    logic       flag_stall;

    logic       arch_load;
    logic [3:0] arch_val;

    int checks = 0;
    int errors = 0;

    flag_hazard_ctrl #(.FLAG_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_set_flags (id_set_flags),
        .id_use_flags (id_use_flags),
        .ex_alu_flags (ex_alu_flags),
        .arch_flags   (arch_flags),
        .flush        (flush),
        .hold         (hold),
        .flag_wr_en   (flag_wr_en),
        .flag_wr_data (flag_wr_data),
        .id_flags     (id_flags),
        .flag_stall   (flag_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag register model: updates at the end of the WB cycle
    always @(posedge clk) begin
        if (arch_load)
            arch_flags <= arch_val;
        else if (flag_wr_en)
            arch_flags <= flag_wr_data;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; id_set_flags = 1'b0; id_use_flags = 1'b0; ex_alu_flags = 4'b0000;
        flush = 1'b0; hold = 1'b0; arch_load = 1'b1; arch_val = 4'b1010;
        cyc(); cyc();
        settle();
        chk("rst_wr_en", {3'b0, flag_wr_en}, 4'b0000);
        chk("rst_wr_data", flag_wr_data, 4'b0000);
        chk("rst_stall", {3'b0, flag_stall}, 4'b0000);
        chk("rst_id_flags", id_flags, 4'b1010);
        cyc();
        reset = 1'b1; arch_load = 1'b0;

        // SUBS in ID, then dependent B.cond behind it
        cyc(); id_set_flags = 1'b1;
        cyc(); id_set_flags = 1'b0; id_use_flags = 1'b1; ex_alu_flags = 4'b0100;
        settle();
`ifdef FLAG_EX_FWD_EN
        chk("b2b_fwd_id_flags", id_flags, 4'b0100);
        chk("b2b_fwd_stall", {3'b0, flag_stall}, 4'b0000);
`else
        chk("b2b_stall", {3'b0, flag_stall}, 4'b0001);
`endif
        cyc(); ex_alu_flags = 4'b1111;
        settle();
        chk("b2b_after_stall", {3'b0, flag_stall}, 4'b0000);
        chk("b2b_mem_id_flags", id_flags, 4'b0100);
        cyc(); id_use_flags = 1'b0;
        settle();
        chk("b2b_commit_en", {3'b0, flag_wr_en}, 4'b0001);
        chk("b2b_commit_data", flag_wr_data, 4'b0100);
        cyc();
        settle();
        chk("b2b_commit_once", {3'b0, flag_wr_en}, 4'b0000);
        chk("b2b_arch", id_flags, 4'b0100);

        // Single ADDS: commit two cycles after its EX cycle
        cyc(); id_set_flags = 1'b1;
        cyc(); id_set_flags = 1'b0; ex_alu_flags = 4'b0110;
        settle();
        chk("adds_ex_no_wr", {3'b0, flag_wr_en}, 4'b0000);
        cyc(); ex_alu_flags = 4'b0000;
        settle();
        chk("adds_mem_no_wr", {3'b0, flag_wr_en}, 4'b0000);
        cyc();
        settle();
        chk("adds_wr_en", {3'b0, flag_wr_en}, 4'b0001);
        chk("adds_wr_data", flag_wr_data, 4'b0110);
        cyc();
        settle();
        chk("adds_wr_done", {3'b0, flag_wr_en}, 4'b0000);
        chk("adds_wr_data_idle", flag_wr_data, 4'b0000);
        chk("adds_arch", arch_flags, 4'b0110);

        // Two writers back to back, B.cond two cycles after the second
        cyc(); id_set_flags = 1'b1;
        cyc(); ex_alu_flags = 4'b0001;
        cyc(); id_set_flags = 1'b0; ex_alu_flags = 4'b1000;
        cyc(); id_use_flags = 1'b1; ex_alu_flags = 4'b1111;
        settle();
        chk("two_youngest", id_flags, 4'b1000);
        chk("two_no_stall", {3'b0, flag_stall}, 4'b0000);
        chk("two_first_commit", flag_wr_data, 4'b0001);
        cyc(); id_use_flags = 1'b0;
        settle();
        chk("two_second_en", {3'b0, flag_wr_en}, 4'b0001);
        chk("two_second_commit", flag_wr_data, 4'b1000);
        cyc();
        settle();
        chk("two_arch", id_flags, 4'b1000);

        // Hold for three cycles with a writer in MEM
        cyc(); id_set_flags = 1'b1;
        cyc(); id_set_flags = 1'b0; ex_alu_flags = 4'b0011;
        cyc(); hold = 1'b1; ex_alu_flags = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hold_no_wr", {3'b0, flag_wr_en}, 4'b0000);
            chk("hold_mem_fwd", id_flags, 4'b0011);
            cyc();
        end
        hold = 1'b0;
        settle();
        chk("hold_release_no_wr", {3'b0, flag_wr_en}, 4'b0000);
        cyc();
        settle();
        chk("hold_commit_en", {3'b0, flag_wr_en}, 4'b0001);
        chk("hold_commit_data", flag_wr_data, 4'b0011);
        cyc();
        settle();
        chk("hold_commit_once", {3'b0, flag_wr_en}, 4'b0000);
        chk("hold_arch", arch_flags, 4'b0011);

        // Flushed writer never reaches EX and never commits
        cyc(); id_set_flags = 1'b1; flush = 1'b1;
        cyc(); id_set_flags = 1'b0; flush = 1'b0; id_use_flags = 1'b1; ex_alu_flags = 4'b1100;
        settle();
        chk("flush_no_stall", {3'b0, flag_stall}, 4'b0000);
        chk("flush_id_flags", id_flags, 4'b0011);
        cyc(); id_use_flags = 1'b0;
        settle();
        chk("flush_no_wr_mem", {3'b0, flag_wr_en}, 4'b0000);
        cyc();
        settle();
        chk("flush_no_wr_wb", {3'b0, flag_wr_en}, 4'b0000);
        chk("flush_arch", arch_flags, 4'b0011);

        // Reset while a writer sits in WB discards it immediately
        cyc(); id_set_flags = 1'b1; arch_load = 1'b1; arch_val = 4'b1010;
        cyc(); id_set_flags = 1'b0; arch_load = 1'b0; ex_alu_flags = 4'b0101;
        cyc();
        cyc();
        settle();
        chk("pre_rst_wr_en", {3'b0, flag_wr_en}, 4'b0001);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_wr_en", {3'b0, flag_wr_en}, 4'b0000);
        chk("mid_rst_wr_data", flag_wr_data, 4'b0000);
        chk("mid_rst_stall", {3'b0, flag_stall}, 4'b0000);
        chk("mid_rst_id_flags", id_flags, 4'b1010);
        cyc(); reset = 1'b1;
        cyc();
        settle();
        chk("post_rst_arch", arch_flags, 4'b1010);
        chk("post_rst_no_wr", {3'b0, flag_wr_en}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
